// File: rtl/merge_sort_pkg.sv
// Shared types and constants for the block merge sort controller.
package merge_sort_pkg;
  localparam int N_ELEM_DEF = 32;
  localparam int QUAD       = 4;

  typedef enum logic [1:0] {IDLE, LOAD, MERGE} state_t;
endpackage

// File: rtl/merge_ptr_gen.sv
// Run pointers for the 2-way merge passes: heads of runs A/B, destination
// address, head select, and end-of-pass / final-pass flags.
module merge_ptr_gen
  import merge_sort_pkg::*;
#(
  parameter  int N_ELEM = N_ELEM_DEF,
  localparam int AW     = $clog2(N_ELEM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init,
  input  logic          en,
  input  logic          a_le_b,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  output logic [AW-1:0] wr_addr,
  output logic          sel_b,
  output logic          src_bank,
  output logic          pass_end,
  output logic          final_pass
);

  localparam logic [AW:0] HALF = (AW+1)'(N_ELEM / 2);
  localparam logic [AW:0] FULL = (AW+1)'(N_ELEM);
  localparam logic [AW:0] QLEN = (AW+1)'(QUAD);

  // One extra bit so that 2L and base+2L can reach N_ELEM without wrapping.
  logic [AW:0]   ia, ib, len, base;
  logic [AW-1:0] pass_idx;
  logic [AW:0]   two_len, sum_a, sum_b, sum_w;
  logic          sel_raw, pair_end, last_pair;

  always_comb begin
    two_len   = len << 1;
    sum_a     = base + ia;
    sum_b     = base + len + ib;
    sum_w     = base + ia + ib;
    pair_end  = (ia + ib) == (two_len - 1'b1);
    last_pair = (base + two_len) == FULL;
    // An exhausted run forces the other; ties take A so the sort stays stable.
    if (ia == len)      sel_raw = 1'b1;
    else if (ib == len) sel_raw = 1'b0;
    else                sel_raw = ~a_le_b;
  end

  assign rd_addr_a  = sum_a[AW-1:0];
  assign rd_addr_b  = sum_b[AW-1:0];
  assign wr_addr    = sum_w[AW-1:0];
  assign sel_b      = en & sel_raw;
  assign src_bank   = pass_idx[0];
  assign final_pass = (len == HALF);
  assign pass_end   = en & pair_end & last_pair;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ia       <= '0;
      ib       <= '0;
      len      <= '0;
      base     <= '0;
      pass_idx <= '0;
    end else if (init) begin
      ia       <= '0;
      ib       <= '0;
      len      <= QLEN;
      base     <= '0;
      pass_idx <= '0;
    end else if (en) begin
      if (pair_end) begin
        ia <= '0;
        ib <= '0;
        if (last_pair) begin
          base <= '0;
          if (final_pass) begin
            len      <= '0;
            pass_idx <= '0;
          end else begin
            len      <= two_len;
            pass_idx <= pass_idx + 1'b1;
          end
        end else begin
          base <= base + two_len;
        end
      end else if (sel_raw) begin
        ib <= ib + 1'b1;
      end else begin
        ia <= ia + 1'b1;
      end
    end
  end

endmodule

// File: rtl/merge_sort_ctrl.sv
// Sequencing controller for the block merge sorter: load quads, then merge passes.
// Optional sticky BlkIn-while-busy flag when MERGE_SORT_CTRL_ERR_EN is defined.
module merge_sort_ctrl
  import merge_sort_pkg::*;
#(
  parameter  int N_ELEM = N_ELEM_DEF,
  localparam int AW     = $clog2(N_ELEM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          BlkIn,
  output logic          ld_we,
  output logic [AW-3:0] ld_addr,
  output logic          src_bank,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  input  logic          a_le_b,
  output logic          sel_b,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          OutValid,
  output logic          busy,
  output logic          done
`ifdef MERGE_SORT_CTRL_ERR_EN
  ,
  output logic          blk_err
`endif
);

  localparam logic [AW-3:0] LAST_BEAT = (AW-2)'(N_ELEM / QUAD - 1);

  state_t        state, state_n;
  logic [AW-3:0] beat, beat_n;
  logic          init, en, pass_end, final_pass;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    beat_n  = beat;
    ld_we   = 1'b0;
    ld_addr = '0;
    init    = 1'b0;
    en      = 1'b0;
    unique case (state)
      IDLE: begin
        // rst gates the accept so a BlkIn coinciding with reset is dropped.
        if (BlkIn && !rst) begin
          ld_we   = 1'b1;
          state_n = LOAD;
          beat_n  = (AW-2)'(1);
        end
      end
      LOAD: begin
        ld_we   = 1'b1;
        ld_addr = beat;
        if (beat == LAST_BEAT) begin
          state_n = MERGE;
          beat_n  = '0;
          init    = 1'b1;
        end else begin
          beat_n = beat + 1'b1;
        end
      end
      MERGE: begin
        en = 1'b1;
        if (pass_end && final_pass) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign wr_en    = en & ~final_pass;
  assign OutValid = en & final_pass;
  assign done     = pass_end & final_pass;

  merge_ptr_gen #(.N_ELEM(N_ELEM)) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .en        (en),
    .a_le_b    (a_le_b),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr_addr   (wr_addr),
    .sel_b     (sel_b),
    .src_bank  (src_bank),
    .pass_end  (pass_end),
    .final_pass(final_pass)
  );

`ifdef MERGE_SORT_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)              blk_err <= 1'b0;
    else if (BlkIn && busy) blk_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_merge_sort_ctrl.sv
// Self-checking bench for merge_sort_ctrl (N=32) with a behavioural datapath
// model (sort4, two banks, comparator) and a scoreboard of sorted outputs.
module tb_merge_sort_ctrl;

  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, BlkIn, a_le_b;
  logic          ld_we, src_bank, sel_b, wr_en, OutValid, busy, done;
  logic [AW-3:0] ld_addr;
  logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr;
`ifdef MERGE_SORT_CTRL_ERR_EN
  logic          blk_err;
`endif

  merge_sort_ctrl #(.N_ELEM(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .BlkIn    (BlkIn),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .src_bank (src_bank),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .a_le_b   (a_le_b),
    .sel_b    (sel_b),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .OutValid (OutValid),
    .busy     (busy),
    .done     (done)
`ifdef MERGE_SORT_CTRL_ERR_EN
    ,
    .blk_err  (blk_err)
`endif
  );

  always #5 clk = ~clk;

  logic signed [7:0] mem [2][N];
  logic signed [7:0] blk_data [N];
  int q[$];
  int cyc = 0, t0 = 0, done_cyc = -1;
  int n_vec = 0, n_err = 0;
  bit mon = 1'b0, eq_test = 1'b0, pulse_test = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  assign a_le_b = (mem[src_bank][rd_addr_a] <= mem[src_bank][rd_addr_b]);

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ld_we"},    ld_we,     0);
    check({tag, "_ld_addr"},  ld_addr,   0);
    check({tag, "_src_bank"}, src_bank,  0);
    check({tag, "_rd_a"},     rd_addr_a, 0);
    check({tag, "_rd_b"},     rd_addr_b, 0);
    check({tag, "_sel_b"},    sel_b,     0);
    check({tag, "_wr_en"},    wr_en,     0);
    check({tag, "_wr_addr"},  wr_addr,   0);
    check({tag, "_outvalid"}, OutValid,  0);
    check({tag, "_busy"},     busy,      0);
    check({tag, "_done"},     done,      0);
  endtask

  // kind 0: 127 down to 96, kind 1: all -5, kind 2: random.
  task automatic start_block(input int kind);
    int s[N];
    int tmp;
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       blk_data[i] = 8'(127 - i);
        1:       blk_data[i] = -8'sd5;
        default: blk_data[i] = 8'($urandom_range(0, 255));
      endcase
      s[i] = int'(blk_data[i]);
    end
    for (int i = 1; i < N; i++)
      for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
        tmp = s[j]; s[j] = s[j-1]; s[j-1] = tmp;
      end
    for (int i = 0; i < N; i++) q.push_back(s[i]);
    t0    = cyc;
    mon   = 1'b1;
    BlkIn = 1'b1;
    @(posedge clk); #1;
    BlkIn = 1'b0;
  endtask

  // Monitor, scoreboard and datapath model, all away from the active edge.
  always @(negedge clk) begin
    int rel, exp_v;
    logic signed [7:0] head, t;
    logic signed [7:0] s4 [4];
    head = sel_b ? mem[src_bank][rd_addr_b] : mem[src_bank][rd_addr_a];
    if (mon) begin
      rel = cyc - t0;
      check("ld_we",    ld_we,    int'(rel < 8));
      if (rel < 8) check("ld_addr", ld_addr, rel);
      check("wr_en",    wr_en,    int'(rel >= 8 && rel < 72));
      check("outvalid", OutValid, int'(rel >= 72 && rel < 104));
      check("done",     done,     int'(rel == 103));
      check("busy",     busy,     int'(rel >= 1 && rel < 104));
      if (rel >= 8 && rel < 104) check("src_bank", src_bank, ((rel - 8) / 32) % 2);
      if (eq_test && rel >= 8 && rel < 16) check("sel_b_tie", sel_b, int'(rel >= 12));
`ifdef MERGE_SORT_CTRL_ERR_EN
      if (pulse_test) check("blk_err", blk_err, int'(rel >= 51));
`endif
    end
    if (done) done_cyc = cyc;
    if (OutValid) begin
      if (q.size() == 0) begin
        check("sort_out_extra", 1, 0);
      end else begin
        exp_v = q.pop_front();
        check("sort_out", int'(head), exp_v);
      end
    end
    if (ld_we) begin
      for (int k = 0; k < 4; k++) s4[k] = blk_data[4*ld_addr + k];
      for (int i = 0; i < 3; i++)
        for (int k = 0; k < 3 - i; k++)
          if (s4[k] > s4[k+1]) begin
            t = s4[k]; s4[k] = s4[k+1]; s4[k+1] = t;
          end
      for (int k = 0; k < 4; k++) mem[0][4*ld_addr + k] = s4[k];
    end
    if (wr_en) mem[~src_bank][wr_addr] = head;
  end

  initial begin
    int e_t0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < N; i++) mem[b][i] = '0;
    rst   = 1'b1;
    BlkIn = 1'b0;

    // Reset held, then BlkIn coinciding with reset must be dropped.
    repeat (3) @(posedge clk);
    @(negedge clk) check_idle("reset");
    @(posedge clk); #1;
    BlkIn = 1'b1;
    @(negedge clk) check("ld_we_in_rst", ld_we, 0);
    @(posedge clk); #1;
    rst   = 1'b0;
    BlkIn = 1'b0;
    @(negedge clk) check_idle("post_rst");
    repeat (2) @(negedge clk) check("no_ld_we", ld_we, 0);

    // Descending data.
    @(posedge clk); #1;
    start_block(0);
    repeat (106) @(posedge clk); #1;
    check("done_at_a", done_cyc - t0, 103);
    check("q_empty_a", q.size(), 0);

    // All-equal data: ties take A.
    eq_test = 1'b1;
    start_block(1);
    repeat (106) @(posedge clk); #1;
    eq_test = 1'b0;
    check("done_at_b", done_cyc - t0, 103);
    check("q_empty_b", q.size(), 0);

    // Extra BlkIn while busy is ignored.
    pulse_test = 1'b1;
    start_block(2);
    repeat (49) @(posedge clk); #1;
    BlkIn = 1'b1;
    @(posedge clk); #1;
    BlkIn = 1'b0;
    repeat (56) @(posedge clk); #1;
    pulse_test = 1'b0;
    check("done_at_c", done_cyc - t0, 103);
    check("q_empty_c", q.size(), 0);
`ifdef MERGE_SORT_CTRL_ERR_EN
    check("blk_err_held", blk_err, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk) check("blk_err_clr", blk_err, 0);
    @(posedge clk); #1;
`endif

    // Reset mid-merge, then a fresh block.
    start_block(2);
    repeat (29) @(posedge clk); #1;
    rst = 1'b1;
    mon = 1'b0;
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk) check_idle("mid_rst");
    @(posedge clk); #1;
    start_block(2);
    repeat (106) @(posedge clk); #1;
    check("done_at_d", done_cyc - t0, 103);
    check("q_empty_d", q.size(), 0);

    // Back-to-back blocks: second BlkIn on the cycle the first returns to IDLE.
    start_block(2);
    e_t0 = t0;
    repeat (103) @(posedge clk); #1;
    start_block(0);
    repeat (106) @(posedge clk); #1;
    check("done_at_b2b", done_cyc - e_t0, 207);
    check("q_empty_b2b", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
